register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
Parametrised successor to the core's integer register file. Adds N read ports, write-through bypass, optional hardwired-zero entry, a per-register pending scoreboard for the pipeline hazard unit, and a sequential post-reset clear sweep so the array maps onto RAM-style storage without an all-entry reset.
Sits between decode (reads, issue) and writeback (write). Its Busy outputs feed the stall logic.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of entries; power of two, at least 2
NRD, 2, number of read ports, at least 1
ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes and is never pending
AW (localparam), clog2(NREGS), address width

Ports:
CLK  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
WE  in  1  writeback write enable
A3  in  AW  write address
WD  in  XLEN  write data
RA  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
RD  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
Issue  in  1  mark destination IssueA as pending
IssueA  in  AW  destination register of the issued instruction
Busy  out  NRD  Busy[i] = register addressed by RA port i still has an outstanding write
Ready  out  1  array cleared, accepting traffic

Behaviour:
- One clock (CLK). Synchronous active-high Reset. Reset is sampled only on the rising edge of CLK.
- FSM states: CLEAR and RUN.
  - Reset high at an edge: state=CLEAR, ptr=0, all pending bits=0, Ready=0.
  - While Reset stays high, the FSM holds in CLEAR with ptr=0 and writes nothing.
- CLEAR sweep, with Reset low:
  - Each edge writes 0 to entry ptr, then ptr increments.
  - The edge that writes entry NREGS-1 moves the state to RUN.
  - Ready is registered: it is 1 exactly NREGS edges after the first edge at which Reset is low.
- During CLEAR:
  - WE and Issue are ignored.
  - RD reads 0 on every port and Busy reads 0.
- Reset asserted mid-operation, in either state: restart CLEAR from ptr=0 and clear all pending bits. Array contents are overwritten by the sweep.
- RUN write: on the edge with WE=1, entry A3 is set to WD. If ZERO_REG=1 and A3=0, the write is dropped.
- RUN read (combinational, zero latency), per port i:
  - If ZERO_REG=1 and RA_i=0, RD_i=0.
  - Else if WE=1 and A3=RA_i (and the write is not dropped), RD_i=WD. This is the write-through bypass.
  - Else RD_i=entry[RA_i].
- Scoreboard (NREGS pending bits, registered, RUN only):
  - Issue=1 sets pend[IssueA], except IssueA=0 when ZERO_REG=1.
  - WE=1 clears pend[A3].
  - Issue and WE on the same address in the same cycle: the set wins, because a new producer is outstanding.
  - Issue and WE on different addresses: both take effect.
- Busy_i = pend[RA_i] AND NOT (WE=1 AND A3=RA_i). A same-cycle writeback releases the stall, consistent with the bypass. Busy_i=0 for entry 0 when ZERO_REG=1.
- Issue to a register that is already pending: it stays pending. No counting; one outstanding producer per register is assumed by the pipeline.
- No X propagation: all outputs are defined from the first edge with Reset high.

Decomposition:
- Shared package holds:
  - state encoding (ST_CLEAR, ST_RUN)
  - default widths XLEN_DEF=32, NREGS_DEF=32
  - zero-register index constant
- One natural sub-module, regfile_sb_bypass: per-port read mux and Busy logic. It is instantiated NRD times in a generate loop.
- Array, FSM and scoreboard stay in the top module.

Test Plan:
- Reset for 2 cycles then release. Ready=0 for edges 1..31 after release and Ready=1 on edge 32. Reading entries 1..31 gives 0. WE/Issue pulsed during the sweep have no effect.
- RUN, WE=1, A3=5, WD=0xDEADBEEF with RA0=5 in the same cycle: RD0=0xDEADBEEF combinationally. On the next cycle, with WE=0, RD0 still reads 0xDEADBEEF.
- ZERO_REG=1, WE=1, A3=0, WD=0x12345678: RD=0 on all ports, then and afterwards. Issue with IssueA=0 leaves Busy=0.
- Issue IssueA=7, then RA1=7 next cycle: Busy[1]=1. In the cycle WE=1, A3=7, Busy[1]=0 and RD1=WD. After that edge, Busy[1]=0.
- Same cycle Issue IssueA=9 and WE A3=9: pend[9]=1 after the edge. Separately, Issue 3 with WE 4 in one cycle: pend[3]=1 and pend[4]=0.
- Reset pulsed for one cycle while pend[7]=1 and entry 5=0xDEADBEEF: Ready drops next edge, Busy=0, and after 32 edges entry 5 reads 0. Repeat with NRD=3, NREGS=16: Ready rises after 16 edges.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// register_file_sb_pkg: shared constants for the scoreboarded register file
//   ST_CLEAR/ST_RUN : FSM state encoding (post-reset clear sweep, normal operation)
//   XLEN_DEF/NREGS_DEF : default data width and entry count
//   ZERO_IDX : index of the optional hardwired-zero entry
package register_file_sb_pkg;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;
    localparam int XLEN_DEF = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_IDX = 0;
endpackage

// File: rtl/register_file_sb_bypass.sv
// regfile_sb_bypass: one read port's data mux and hazard flag
//   run  : array is out of the clear sweep
//   we   : qualified writeback (RUN and not a dropped zero-entry write)
//   a3/wd: writeback address/data, ra: read address
//   q    : stored entry at ra, pend: scoreboard bit at ra
//   rd   : read data with write-through bypass, busy: outstanding producer at ra
module regfile_sb_bypass
    import register_file_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            run,
    input  logic            we,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra,
    input  logic [XLEN-1:0] q,
    input  logic            pend,
    output logic [XLEN-1:0] rd,
    output logic            busy
);
    logic zero;
    logic hit;
    always_comb begin
        zero = (ZERO_REG != 0) && (ra == AW'(ZERO_IDX));
        hit = we && (a3 == ra);
        rd = (!run || zero) ? '0 : hit ? wd : q;
        // a same-cycle writeback satisfies the consumer through the bypass
        busy = run && !zero && pend && !hit;
    end
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with bypass, pending scoreboard and clear sweep
//   CLK, Reset     : clock, synchronous active-high reset
//   WE, A3, WD     : writeback port
//   RA, RD         : NRD packed read ports (address AW bits, data XLEN bits each)
//   Issue, IssueA  : mark destination register as pending
//   Busy           : per read port, addressed register has an outstanding write
//   Ready          : clear sweep finished, accepting traffic
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                WE,
    input  logic [AW-1:0]       A3,
    input  logic [XLEN-1:0]     WD,
    input  logic [NRD*AW-1:0]   RA,
    output logic [NRD*XLEN-1:0] RD,
    input  logic                Issue,
    input  logic [AW-1:0]       IssueA,
    output logic [NRD-1:0]      Busy,
    output logic                Ready
);
    logic [XLEN-1:0] mem [NREGS];
    logic [0:0] state;
    logic [AW-1:0] ptr;
    logic [NREGS-1:0] pend;
    logic ready_q;
    logic run;
    logic wr_ok;
    logic iss_ok;
    logic mem_we;
    logic [AW-1:0] mem_a;
    logic [XLEN-1:0] mem_d;
    logic [NREGS-1:0] set_m;
    logic [NREGS-1:0] clr_m;

    always_comb begin
        run = state == ST_RUN;
        wr_ok = run && WE && !((ZERO_REG != 0) && (A3 == AW'(ZERO_IDX)));
        iss_ok = run && Issue && !((ZERO_REG != 0) && (IssueA == AW'(ZERO_IDX)));
        // the sweep shares the single write port, so no per-entry reset is needed
        mem_we = !Reset && (!run || wr_ok);
        mem_a = run ? A3 : ptr;
        mem_d = run ? WD : '0;
        set_m = iss_ok ? (NREGS'(1) << IssueA) : '0;
        clr_m = wr_ok ? (NREGS'(1) << A3) : '0;
    end

    always_ff @(posedge CLK)
        if (mem_we)
            mem[mem_a] <= mem_d;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ST_CLEAR;
            ptr <= '0;
            pend <= '0;
            ready_q <= 1'b0;
        end else if (!run) begin
            ptr <= ptr + AW'(1);
            if (ptr == AW'(NREGS - 1)) begin
                state <= ST_RUN;
                ready_q <= 1'b1;
            end
        end else begin
            // set applied after clear: a new producer outranks the retiring one
            pend <= (pend & ~clr_m) | set_m;
        end
    end

    assign Ready = ready_q;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0] ra;
        assign ra = RA[i*AW +: AW];
        regfile_sb_bypass #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG)) u_byp (
            .run(run),
            .we(wr_ok),
            .a3(A3),
            .wd(WD),
            .ra(ra),
            .q(mem[ra]),
            .pend(pend[ra]),
            .rd(RD[i*XLEN +: XLEN]),
            .busy(Busy[i])
        );
    end
endmodule
